mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port cell memory (16-bit words, 3-word cons cells) among N requesters:
//  evaluator core, cons allocator and host loader/debug port. Round-robin, one access/cycle,
//  1-cycle read latency. Sits between requesters and the memory module; the core does not drive memory directly.
// PARAMETERS
//  NUM_REQ     3    number of requesters; index 0 = core, 1 = allocator, 2 = loader
//  ADDR_W      8    word address width (256-word memory)
//  DATA_W      16   word width
//  LOCK_MAX    3    max consecutive beats one requester may hold under lock (one cell)
// PORTS
//  clk        in   1               system clock, rising edge
//  rst_n      in   1               asynchronous, active-low reset
//  req        in   NUM_REQ         access request per requester; held until gnt
//  we         in   NUM_REQ         1 = write, 0 = read; valid with req
//  addr       in   NUM_REQ*ADDR_W  packed word addresses
//  wdata      in   NUM_REQ*DATA_W  packed write data
//  lock       in   NUM_REQ         hold grant for following beats (MEM_ARB_LOCK_EN only)
//  gnt        out  NUM_REQ         one-hot; access issued this cycle
//  rvalid     out  NUM_REQ         one-hot; read data valid, cycle after read gnt
//  rdata      out  DATA_W          read data, broadcast; qualify with rvalid
//  mem_en     out  1               memory access strobe
//  mem_we     out  1               memory write enable
//  mem_addr   out  ADDR_W          memory address
//  mem_wdata  out  DATA_W          memory write data
//  mem_rdata  in   DATA_W          memory read data, 1 cycle after mem_en & !mem_we
// BEHAVIOUR
//  - Reset (rst_n low, async): gnt=0, rvalid=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0,
//    rr_ptr=0, state=ARB_IDLE, lock_cnt=0. Outstanding read dropped: no rvalid after reset.
//  - gnt, mem_* combinational from req/state/rr_ptr; at most one gnt bit per cycle.
//  - Arbitration: first asserted req scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    On grant to i: rr_ptr <= (i+1) mod NUM_REQ at clock edge. No req -> mem_en=0, rr_ptr holds.
//  - Grant cycle: mem_en=1, mem_we=we[i], mem_addr/mem_wdata = requester i slice.
//    Requester sees gnt[i] and may present next access the following cycle (back-to-back ok).
//  - Read: rvalid[i]=1 exactly one cycle after the grant, rdata=mem_rdata. Write: no rvalid.
//  - Throughput: 1 access/cycle total; rvalid of access k coincides with grant of access k+1.
//  - Fairness: with all NUM_REQ requesting continuously, each granted once per NUM_REQ cycles.
//  - Out-of-range: addr >= 2**ADDR_W impossible by width; no checking.
//  - req dropped before gnt is legal; request withdrawn, no access.
//  - FSM: ARB_IDLE (round-robin) / ARB_LOCKED (owner fixed). See CONFIGURATION.
// CONFIGURATION
//  MEM_ARB_LOCK_EN defined:
//   - Grant to i with lock[i]=1 -> ARB_LOCKED, owner=i, lock_cnt=1.
//   - ARB_LOCKED: only owner may be granted; others wait, rr_ptr frozen.
//   - Each owner grant increments lock_cnt; grant with lock[owner]=0, or lock_cnt reaching
//     LOCK_MAX, returns to ARB_IDLE and rr_ptr <= owner+1.
//   - Owner dropping req in ARB_LOCKED: cycle idles, lock kept (lock_cnt unchanged).
//  MEM_ARB_LOCK_EN undefined: lock port present but ignored; FSM never leaves ARB_IDLE.
// TESTING
//  1 reset: rst_n=0 mid-read -> gnt=0, rvalid=0, mem_en=0 immediately; no rvalid after release.
//  2 single read: mem[3]=0x0200, req[0]=1 addr=0x03 we=0 -> gnt[0] cycle t, rvalid[0], rdata=0x0200 at t+1.
//  3 write then read: req[2] writes 0xDEAD to 0x02, then reads 0x02 -> rvalid[2], rdata=0xDEAD.
//  4 contention: req=3'b111 held 6 cycles from rr_ptr=0 -> gnt order 0,1,2,0,1,2; no idle cycle.
//  5 lock (LOCK_EN): req[1] lock=1 for 3 beats writing 0x0000,0x0005,0x0002 at 0x10..0x12 while
//    req[0] pending -> gnt[1] x3 contiguous, then gnt[0]; next arbitration starts at 2.
//  6 lock cap (LOCK_EN): req[1] lock held 5 beats, req[2] pending -> gnt[1] x3, gnt[2], gnt[1].

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port cell memory among NUM_REQ requesters.
// Optional grant locking (up to LOCK_MAX beats per owner) is enabled by defining MEM_ARB_LOCK_EN.
module mem_arbiter #(
  parameter int NUM_REQ  = 3,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 16,
  parameter int LOCK_MAX = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         we,
  input  logic [NUM_REQ*ADDR_W-1:0]  addr,
  input  logic [NUM_REQ*DATA_W-1:0]  wdata,
  input  logic [NUM_REQ-1:0]         lock,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]          rdata,
  output logic                       mem_en,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} state_t;

  state_t             state, state_next;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_next;
  logic [PTR_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [NUM_REQ-1:0] rvalid_q;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);
  logic [PTR_W-1:0] owner, owner_next;
  logic [CNT_W-1:0] lock_cnt, lock_cnt_next;
  logic             sel_lock, owner_req, owner_lock;
`else
  logic unused_lock;
  assign unused_lock = ^lock;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(NUM_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pick the winner: round-robin scan when idle, owner only when locked.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] cand;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    cand    = '0;
`ifdef MEM_ARB_LOCK_EN
    owner_req  = 1'b0;
    owner_lock = 1'b0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (owner == PTR_W'(j)) begin
        owner_req  = req[j];
        owner_lock = lock[j];
      end
    end
`endif
    if (state == ARB_IDLE) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        cand = PTR_W'(idx);
        if (req[cand]) begin
          gnt_any = 1'b1;
          gnt_idx = cand;
        end
      end
    end else begin
`ifdef MEM_ARB_LOCK_EN
      if (owner_req) begin
        gnt_any = 1'b1;
        gnt_idx = owner;
      end
`endif
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
    sel_lock  = 1'b0;
`endif
    for (int j = 0; j < NUM_REQ; j++) begin
      if (gnt_idx == PTR_W'(j)) begin
        sel_we    = we[j];
        sel_addr  = addr[j*ADDR_W +: ADDR_W];
        sel_wdata = wdata[j*DATA_W +: DATA_W];
`ifdef MEM_ARB_LOCK_EN
        sel_lock  = lock[j];
`endif
      end
    end
  end

  // Outputs are forced quiet while reset is asserted, even mid-request.
  always_comb begin
    gnt       = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (gnt_any && rst_n) begin
      gnt[gnt_idx] = 1'b1;
      mem_en       = 1'b1;
      mem_we       = sel_we;
      mem_addr     = sel_addr;
      mem_wdata    = sel_wdata;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = mem_rdata;

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
`ifdef MEM_ARB_LOCK_EN
    owner_next    = owner;
    lock_cnt_next = lock_cnt;
`endif
    if (gnt_any) begin
      if (state == ARB_IDLE) begin
        rr_ptr_next = ptr_inc(gnt_idx);
`ifdef MEM_ARB_LOCK_EN
        if (sel_lock && (LOCK_MAX > 1)) begin
          state_next    = ARB_LOCKED;
          owner_next    = gnt_idx;
          lock_cnt_next = CNT_W'(1);
        end
`endif
      end else begin
`ifdef MEM_ARB_LOCK_EN
        if (!owner_lock || ((lock_cnt + 1'b1) >= CNT_W'(LOCK_MAX))) begin
          state_next    = ARB_IDLE;
          rr_ptr_next   = ptr_inc(owner);
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      rvalid_q <= '0;
`ifdef MEM_ARB_LOCK_EN
      owner    <= '0;
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      rvalid_q <= (mem_en && !mem_we) ? gnt : '0;
`ifdef MEM_ARB_LOCK_EN
      owner    <= owner_next;
      lock_cnt <= lock_cnt_next;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: per-cycle vector table plus hand-written reset sequence.
// Lock vectors follow the MEM_ARB_LOCK_EN build; the default build checks that lock is ignored.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, we, lock;
  logic [23:0] addr;
  logic [47:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  logic [15:0] mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  req, we, lock;
    logic [23:0] addr;
    logic [47:0] wdata;
    logic [2:0]  eg, erv;
    logic [15:0] erd;
  } vec_t;

  vec_t vecs[$];

  mem_arbiter #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(16), .LOCK_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory model with 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] r, input logic [2:0] w, input logic [2:0] l,
                     input logic [23:0] a, input logic [47:0] d,
                     input logic [2:0] eg, input logic [2:0] erv, input logic [15:0] erd);
    vec_t v;
    v.req = r; v.we = w; v.lock = l; v.addr = a; v.wdata = d;
    v.eg = eg; v.erv = erv; v.erd = erd;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t        v;
    logic        ewe;
    logic [7:0]  eaddr;
    logic [15:0] ewd;

    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h03] = 16'h0200;
    mem[8'h05] = 16'h1234;
    mem[8'h10] = 16'hFFFF;
    mem[8'h11] = 16'hFFFF;
    mem[8'h12] = 16'hFFFF;
    mem_rdata = '0;

    //   req     we      lock    addr {r2,r1,r0}     wdata {r2,r1,r0}               gnt     rvalid  rdata
    // single read, write-then-read, contention, withdrawn request
    add(3'b001, 3'b000, 3'b000, {8'h00,8'h00,8'h03}, 48'h0,                      3'b001, 3'b000, 16'h0);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b001, 16'h0200);
    add(3'b100, 3'b100, 3'b000, {8'h02,8'h00,8'h00}, {16'hDEAD,16'h0,16'h0},     3'b100, 3'b000, 16'h0);
    add(3'b100, 3'b000, 3'b000, {8'h02,8'h00,8'h00}, 48'h0,                      3'b100, 3'b000, 16'h0);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b100, 16'hDEAD);
    for (int k = 0; k < 2; k++) begin
      add(3'b111, 3'b000, 3'b000, {8'h05,8'h02,8'h03}, 48'h0, 3'b001, (k == 0) ? 3'b000 : 3'b100, 16'h1234);
      add(3'b111, 3'b000, 3'b000, {8'h05,8'h02,8'h03}, 48'h0, 3'b010, 3'b001, 16'h0200);
      add(3'b111, 3'b000, 3'b000, {8'h05,8'h02,8'h03}, 48'h0, 3'b100, 3'b010, 16'hDEAD);
    end
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b100, 16'h1234);
    add(3'b110, 3'b000, 3'b000, {8'h05,8'h02,8'h03}, 48'h0,                      3'b010, 3'b000, 16'h0);
    add(3'b001, 3'b000, 3'b000, {8'h05,8'h02,8'h03}, 48'h0,                      3'b001, 3'b010, 16'hDEAD);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b001, 16'h0200);
`ifdef MEM_ARB_LOCK_EN
    // 3-beat locked burst with requester 0 waiting, then rr resumes at 2
    add(3'b011, 3'b010, 3'b010, {8'h00,8'h10,8'h03}, {16'h0,16'h0000,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b011, 3'b010, 3'b010, {8'h00,8'h11,8'h03}, {16'h0,16'h0005,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b011, 3'b010, 3'b010, {8'h00,8'h12,8'h03}, {16'h0,16'h0002,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b101, 3'b000, 3'b000, {8'h05,8'h00,8'h03}, 48'h0,                      3'b100, 3'b000, 16'h0);
    add(3'b001, 3'b000, 3'b000, {8'h00,8'h00,8'h03}, 48'h0,                      3'b001, 3'b100, 16'h1234);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b001, 16'h0200);
    // owner drops req while locked: idle cycle, lock kept
    add(3'b010, 3'b010, 3'b010, {8'h00,8'h13,8'h00}, {16'h0,16'h0BEE,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b100, 3'b000, 3'b000, {8'h05,8'h00,8'h00}, 48'h0,                      3'b000, 3'b000, 16'h0);
    add(3'b110, 3'b010, 3'b010, {8'h05,8'h14,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b110, 3'b010, 3'b000, {8'h05,8'h15,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b100, 3'b000, 3'b000, {8'h05,8'h00,8'h00}, 48'h0,                      3'b100, 3'b000, 16'h0);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b100, 16'h1234);
    // lock cap: 5 locked beats requested, requester 2 gets in after 3
    add(3'b110, 3'b010, 3'b010, {8'h05,8'h20,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b110, 3'b010, 3'b010, {8'h05,8'h21,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b110, 3'b010, 3'b010, {8'h05,8'h22,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b110, 3'b010, 3'b010, {8'h05,8'h23,8'h00}, {16'h0,16'h0001,16'h0},     3'b100, 3'b000, 16'h0);
    add(3'b010, 3'b010, 3'b010, {8'h00,8'h23,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b100, 16'h1234);
    add(3'b010, 3'b010, 3'b010, {8'h00,8'h24,8'h00}, {16'h0,16'h0001,16'h0},     3'b010, 3'b000, 16'h0);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b000, 16'h0);
`else
    // lock input has no effect: round-robin continues
    add(3'b011, 3'b000, 3'b010, {8'h00,8'h05,8'h03}, 48'h0,                      3'b010, 3'b000, 16'h0);
    add(3'b011, 3'b000, 3'b010, {8'h00,8'h05,8'h03}, 48'h0,                      3'b001, 3'b010, 16'h1234);
    add(3'b010, 3'b000, 3'b010, {8'h00,8'h05,8'h03}, 48'h0,                      3'b010, 3'b001, 16'h0200);
    add(3'b000, 3'b000, 3'b000, 24'h0,               48'h0,                      3'b000, 3'b010, 16'h1234);
`endif

    rst_n = 1'b0;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_gnt", gnt, 3'b000);
    chk("reset_rvalid", rvalid, 3'b000);
    chk("reset_mem_en", mem_en, 1'b0);
    chk("reset_mem_addr", mem_addr, 8'h00);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      v = vecs[i];
      req = v.req; we = v.we; lock = v.lock; addr = v.addr; wdata = v.wdata;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), gnt, v.eg);
      chk($sformatf("v%0d_mem_en", i), mem_en, |v.eg);
      chk($sformatf("v%0d_rvalid", i), rvalid, v.erv);
      if (v.erv != 3'b000) chk($sformatf("v%0d_rdata", i), rdata, v.erd);
      if (v.eg != 3'b000) begin
        ewe = 1'b0; eaddr = '0; ewd = '0;
        for (int j = 0; j < 3; j++) begin
          if (v.eg[j]) begin
            ewe   = v.we[j];
            eaddr = v.addr[j*8 +: 8];
            ewd   = v.wdata[j*16 +: 16];
          end
        end
        chk($sformatf("v%0d_mem_we", i), mem_we, ewe);
        chk($sformatf("v%0d_mem_addr", i), mem_addr, eaddr);
        if (ewe) chk($sformatf("v%0d_mem_wdata", i), mem_wdata, ewd);
      end
      @(posedge clk); #1;
    end

`ifdef MEM_ARB_LOCK_EN
    chk("lock_mem10", mem[8'h10], 16'h0000);
    chk("lock_mem11", mem[8'h11], 16'h0005);
    chk("lock_mem12", mem[8'h12], 16'h0002);
`endif

    // reset while a read is in flight
    req = 3'b010; we = 3'b000; lock = 3'b000; addr = {8'h00,8'h05,8'h00}; wdata = '0;
    @(negedge clk);
    chk("rst_pre_gnt", gnt, 3'b010);
    @(posedge clk); #1;
    chk("rst_pre_rvalid", rvalid, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", gnt, 3'b000);
    chk("rst_async_rvalid", rvalid, 3'b000);
    chk("rst_async_mem_en", mem_en, 1'b0);
    chk("rst_async_mem_we", mem_we, 1'b0);
    chk("rst_async_mem_addr", mem_addr, 8'h00);
    chk("rst_async_mem_wdata", mem_wdata, 16'h0000);
    req = 3'b111;
    @(negedge clk);
    chk("rst_held_gnt", gnt, 3'b000);
    req = 3'b000;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_after_rvalid0", rvalid, 3'b000);
    req = 3'b111; addr = {8'h05,8'h02,8'h03};
    @(negedge clk);
    chk("rst_rrptr_gnt", gnt, 3'b001);
    @(posedge clk); #1;
    req = 3'b000;
    chk("rst_after_rvalid1", rvalid, 3'b001);
    chk("rst_after_rdata", rdata, 16'h0200);
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
